// File: rtl/pdp11_ifetch_pkg.sv
// Shared types for the PDP-11 instruction fetch unit and its decoder.
// Optional fetch tracing in the top is enabled by defining IFETCH_TRACE_EN.
package pdp11_ifetch_pkg;

    typedef enum logic [2:0] {
        SYS     = 3'd0,
        JMP     = 3'd1,
        PSOP    = 3'd2,
        SWAB    = 3'd3,
        BR      = 3'd4,
        SOP     = 3'd5,
        DOP     = 3'd6,
        ILLEGAL = 3'd7
    } inst_class_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH_OP  = 3'd1,
        FETCH_EXT = 3'd2,
        PRESENT   = 3'd3,
        ERR       = 3'd4
    } ifetch_state_t;

    typedef logic [2:0] mode_t;
    typedef logic [2:0] reg_t;

    // Indexed modes always carry a word; autoinc via PC is immediate/absolute
    function automatic logic needs_ext(input mode_t mode, input reg_t rn);
        return (mode == 3'd6) || (mode == 3'd7) ||
               (((mode == 3'd2) || (mode == 3'd3)) && (rn == 3'd7));
    endfunction

endpackage

// File: rtl/pdp11_inst_classify.sv
// Combinational opcode classifier: instruction class and count of
// extension words that follow the opcode.
module pdp11_inst_classify
    import pdp11_ifetch_pkg::*;
#(
    parameter int WORD_SIZE = 16
) (
    input  logic [WORD_SIZE-1:0] word,
    output inst_class_t          inst_class,
    output logic [1:0]           ext_cnt
);

    logic [15:0] w;
    logic        src_ext;
    logic        dst_ext;

    assign w       = word[15:0];
    assign src_ext = needs_ext(w[11:9], w[8:6]);
    assign dst_ext = needs_ext(w[5:3], w[2:0]);

    always_comb begin
        inst_class = ILLEGAL;
        ext_cnt    = 2'd0;
        if (w[15:3] == 13'd0) begin
            inst_class = SYS;
        end else if (w[15:6] == 10'o0001) begin
            inst_class = JMP;
            ext_cnt    = {1'b0, dst_ext};
        end else if (w[15:6] == 10'o0002) begin
            inst_class = PSOP;
        end else if (w[15:6] == 10'o0003) begin
            inst_class = SWAB;
            ext_cnt    = {1'b0, dst_ext};
        end else if ((w[14:11] == 4'd0) && (w[10:8] != 3'd0)) begin
            inst_class = BR;
        end else if (w[14:11] == 4'b0001) begin
            inst_class = SOP;
            ext_cnt    = {1'b0, dst_ext};
        end else if ((w[14:12] != 3'd0) && (w[14:12] != 3'd7)) begin
            inst_class = DOP;
            ext_cnt    = {1'b0, src_ext} + {1'b0, dst_ext};
        end
    end

endmodule

// File: rtl/pdp11_ifetch.sv
// PDP-11 instruction fetch: assembles opcode plus extension words from a
// narrow memory port. IFETCH_TRACE_EN adds simulation-only fetch traces.
module pdp11_ifetch
    import pdp11_ifetch_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int MEM_WIDTH = 8,
    parameter int ADDR_LEN  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_LEN-1:0]  start_pc,
    input  logic                 redirect,
    input  logic [ADDR_LEN-1:0]  redirect_pc,
    output logic                 mem_req,
    output logic [ADDR_LEN-1:0]  mem_addr,
    input  logic                 mem_ack,
    input  logic [MEM_WIDTH-1:0] mem_rdata,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [WORD_SIZE-1:0] inst_word,
    output logic [WORD_SIZE-1:0] ext_word0,
    output logic [WORD_SIZE-1:0] ext_word1,
    output logic [ADDR_LEN-1:0]  inst_pc,
    output logic [1:0]           ext_cnt,
    output logic [2:0]           inst_class,
    output logic                 odd_err,
    output logic                 busy
);

    localparam int BEATS = WORD_SIZE / MEM_WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    ifetch_state_t        state_q, state_d;
    logic [ADDR_LEN-1:0]  addr_q, addr_d;
    logic [ADDR_LEN-1:0]  inst_pc_q, inst_pc_d;
    logic [BW-1:0]        beat_q, beat_d;
    logic [WORD_SIZE-1:0] asm_q, asm_d;
    logic [WORD_SIZE-1:0] inst_word_q, inst_word_d;
    logic [WORD_SIZE-1:0] ext0_q, ext0_d;
    logic [WORD_SIZE-1:0] ext1_q, ext1_d;
    logic [1:0]           ext_cnt_q, ext_cnt_d;
    inst_class_t          cls_q, cls_d;
    logic                 ext_idx_q, ext_idx_d;
    logic                 odd_err_q, odd_err_d;

    logic [WORD_SIZE-1:0] word_asm;
    inst_class_t          cls_w;
    logic [1:0]           cnt_w;
    logic                 go_redir;
    logic                 go_start;
    logic [ADDR_LEN-1:0]  go_pc;
    logic [ADDR_LEN-1:0]  next_pc;

    pdp11_inst_classify #(.WORD_SIZE(WORD_SIZE)) u_classify (
        .word       (word_asm),
        .inst_class (cls_w),
        .ext_cnt    (cnt_w)
    );

    always_comb begin
        word_asm = asm_q;
        word_asm[beat_q*MEM_WIDTH +: MEM_WIDTH] = mem_rdata;
    end

    assign go_redir = redirect && (state_q != IDLE);
    assign go_start = start && ((state_q == IDLE) || (state_q == ERR));
    assign go_pc    = go_redir ? redirect_pc : start_pc;
    assign next_pc  = inst_pc_q + ADDR_LEN'({ext_cnt_q, 1'b0})
                    + ADDR_LEN'(2);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        inst_pc_d   = inst_pc_q;
        beat_d      = beat_q;
        asm_d       = asm_q;
        inst_word_d = inst_word_q;
        ext0_d      = ext0_q;
        ext1_d      = ext1_q;
        ext_cnt_d   = ext_cnt_q;
        cls_d       = cls_q;
        ext_idx_d   = ext_idx_q;
        odd_err_d   = odd_err_q;
        if (go_redir || go_start) begin
            beat_d    = '0;
            ext_idx_d = 1'b0;
            if (go_pc[0]) begin
                state_d   = ERR;
                odd_err_d = 1'b1;
            end else begin
                state_d   = FETCH_OP;
                odd_err_d = 1'b0;
                addr_d    = go_pc;
                inst_pc_d = go_pc;
            end
        end else begin
            unique case (state_q)
                FETCH_OP: if (mem_ack) begin
                    addr_d = addr_q + ADDR_LEN'(1);
                    asm_d  = word_asm;
                    if (beat_q == LAST_BEAT) begin
                        beat_d      = '0;
                        inst_word_d = word_asm;
                        cls_d       = cls_w;
                        ext_cnt_d   = cnt_w;
                        ext0_d      = '0;
                        ext1_d      = '0;
                        ext_idx_d   = 1'b0;
                        state_d     = (cnt_w == 2'd0) ? PRESENT : FETCH_EXT;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
                FETCH_EXT: if (mem_ack) begin
                    addr_d = addr_q + ADDR_LEN'(1);
                    asm_d  = word_asm;
                    if (beat_q == LAST_BEAT) begin
                        beat_d = '0;
                        if (ext_idx_q) ext1_d = word_asm;
                        else           ext0_d = word_asm;
                        if (({1'b0, ext_idx_q} + 2'd1) == ext_cnt_q)
                            state_d = PRESENT;
                        else
                            ext_idx_d = 1'b1;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
                PRESENT: if (inst_ready) begin
                    state_d   = FETCH_OP;
                    addr_d    = next_pc;
                    inst_pc_d = next_pc;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            inst_pc_q   <= '0;
            beat_q      <= '0;
            asm_q       <= '0;
            inst_word_q <= '0;
            ext0_q      <= '0;
            ext1_q      <= '0;
            ext_cnt_q   <= '0;
            cls_q       <= SYS;
            ext_idx_q   <= 1'b0;
            odd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            inst_pc_q   <= inst_pc_d;
            beat_q      <= beat_d;
            asm_q       <= asm_d;
            inst_word_q <= inst_word_d;
            ext0_q      <= ext0_d;
            ext1_q      <= ext1_d;
            ext_cnt_q   <= ext_cnt_d;
            cls_q       <= cls_d;
            ext_idx_q   <= ext_idx_d;
            odd_err_q   <= odd_err_d;
        end
    end

    assign mem_req    = (state_q == FETCH_OP) || (state_q == FETCH_EXT);
    assign mem_addr   = addr_q;
    assign inst_valid = (state_q == PRESENT);
    assign busy       = (state_q != IDLE);
    assign inst_word  = inst_word_q;
    assign ext_word0  = ext0_q;
    assign ext_word1  = ext1_q;
    assign inst_pc    = inst_pc_q;
    assign ext_cnt    = ext_cnt_q;
    assign inst_class = cls_q;
    assign odd_err    = odd_err_q;

`ifdef IFETCH_TRACE_EN
    localparam int INST_FETCH = 2;
    always @(posedge clk) begin
        if (rst_n && mem_req && mem_ack && !redirect)
            $display("mem_trace_f %0d %h", INST_FETCH, mem_addr);
        if (rst_n && inst_valid && inst_ready && !redirect)
            $display("txn_f %h %h %0d", inst_pc, inst_word, inst_class);
    end
`else
`endif

endmodule
